// File: rtl/e_pipe_reg_pkg.sv
// Shared pipeline constants, field widths and the E-stage register layout.
// Also provides the canonical bubble (NOP) image of the E-stage register.
package e_pipe_reg_pkg;

  localparam int ICODE_W = 6;
  localparam int FUN_W   = 6;
  localparam int REG_W   = 5;
  localparam int STAT_W  = 3;
  localparam int WORD_W  = 32;

  localparam logic [REG_W-1:0]   RNONE = 5'h1F;
  localparam logic [ICODE_W-1:0] INOP  = 6'h3F;
  localparam logic [STAT_W-1:0]  SAOK  = 3'd1;
  localparam logic [STAT_W-1:0]  SADR  = 3'd3;
  localparam logic [STAT_W-1:0]  SINS  = 3'd4;
  localparam logic [STAT_W-1:0]  SBUB  = 3'd5;

  typedef struct packed {
    logic [STAT_W-1:0]  stat;
    logic [ICODE_W-1:0] icode;
    logic [FUN_W-1:0]   ifun;
    logic [WORD_W-1:0]  val_c;
    logic [WORD_W-1:0]  val_a;
    logic [WORD_W-1:0]  val_b;
    logic [REG_W-1:0]   src_a;
    logic [REG_W-1:0]   src_b;
    logic [REG_W-1:0]   dst_e;
    logic [REG_W-1:0]   dst_m;
    logic               valid;
  } e_reg_t;

  function automatic e_reg_t bubble_regs();
    e_reg_t r;
    r.stat  = SBUB;
    r.icode = INOP;
    r.ifun  = '0;
    r.val_c = '0;
    r.val_a = '0;
    r.val_b = '0;
    r.src_a = RNONE;
    r.src_b = RNONE;
    r.dst_e = RNONE;
    r.dst_m = RNONE;
    r.valid = 1'b0;
    return r;
  endfunction

endpackage

// File: rtl/e_pipe_reg_sat_cnt32.sv
// Saturating 32-bit event counter with synchronous clear and async reset.
// Count updates one cycle after inc; sticks at all-ones instead of wrapping.
module sat_cnt32 (
  input  logic        clk,
  input  logic        rst,
  input  logic        inc,
  input  logic        clr,
  output logic [31:0] cnt
);

  logic [31:0] cnt_q;
  logic [31:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc && (cnt_q != 32'hFFFF_FFFF)) begin
      cnt_d = cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/e_pipe_reg.sv
// Decode->Execute pipeline register with stall, bubble injection and bubble count.
// One-cycle latency; stall holds contents, bubble (wins over stall) loads a NOP.
module e_pipe_reg
  import e_pipe_reg_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               E_stall,
  input  logic               E_bubble,
  input  logic [STAT_W-1:0]  d_stat,
  input  logic [ICODE_W-1:0] d_icode,
  input  logic [FUN_W-1:0]   d_ifun,
  input  logic [WORD_W-1:0]  d_valC,
  input  logic [WORD_W-1:0]  d_valA,
  input  logic [WORD_W-1:0]  d_valB,
  input  logic [REG_W-1:0]   d_srcA,
  input  logic [REG_W-1:0]   d_srcB,
  input  logic [REG_W-1:0]   d_dstE,
  input  logic [REG_W-1:0]   d_dstM,
  output logic [STAT_W-1:0]  E_stat,
  output logic [ICODE_W-1:0] E_icode,
  output logic [FUN_W-1:0]   E_ifun,
  output logic [WORD_W-1:0]  E_valC,
  output logic [WORD_W-1:0]  E_valA,
  output logic [WORD_W-1:0]  E_valB,
  output logic [REG_W-1:0]   E_srcA,
  output logic [REG_W-1:0]   E_srcB,
  output logic [REG_W-1:0]   E_dstE,
  output logic [REG_W-1:0]   E_dstM,
  output logic               E_valid,
  output logic [31:0]        bubble_cnt
);

  e_reg_t e_q;
  e_reg_t e_d;

  always_comb begin
    e_d = e_q;
    if (E_bubble) begin
      e_d = bubble_regs();
    end else if (!E_stall) begin
      e_d.stat  = d_stat;
      e_d.icode = d_icode;
      e_d.ifun  = d_ifun;
      e_d.val_c = d_valC;
      e_d.val_a = d_valA;
      e_d.val_b = d_valB;
      e_d.src_a = d_srcA;
      e_d.src_b = d_srcB;
      e_d.dst_e = d_dstE;
      e_d.dst_m = d_dstM;
      e_d.valid = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      e_q <= bubble_regs();
    end else begin
      e_q <= e_d;
    end
  end

  // Every bubble edge counts, including those that override a stall.
  sat_cnt32 u_bcnt (
    .clk (clk),
    .rst (rst),
    .inc (E_bubble),
    .clr (1'b0),
    .cnt (bubble_cnt)
  );

  assign E_stat  = e_q.stat;
  assign E_icode = e_q.icode;
  assign E_ifun  = e_q.ifun;
  assign E_valC  = e_q.val_c;
  assign E_valA  = e_q.val_a;
  assign E_valB  = e_q.val_b;
  assign E_srcA  = e_q.src_a;
  assign E_srcB  = e_q.src_b;
  assign E_dstE  = e_q.dst_e;
  assign E_dstM  = e_q.dst_m;
  assign E_valid = e_q.valid;

endmodule

// File: doc/e_pipe_reg.md
E_PIPE_REG -- requirements
Module: e_pipe_reg

Interface
REQ-001 SHALL have ports: clk, input, 1, sole clock, all state updates on rising edge.
REQ-002 SHALL have ports: rst, input, 1, asynchronous active-high reset.
REQ-003 SHALL have ports: E_stall, input, 1, hold current E contents.
REQ-004 SHALL have ports: E_bubble, input, 1, load NOP bubble instead of decode outputs.
REQ-005 SHALL have ports: d_stat, input, 3, decode-stage status code.
REQ-006 SHALL have ports: d_icode, input, 6, opcode; d_ifun, input, 6, funct.
REQ-007 SHALL have ports: d_valC, input, 32, sign/zero-extended immediate.
REQ-008 SHALL have ports: d_valA and d_valB, input, 32 each, forwarded operands from decode forwarding muxes.
REQ-009 SHALL have ports: d_srcA, d_srcB, d_dstE, d_dstM, input, 5 each, register IDs.
REQ-010 SHALL have ports: E_stat, E_icode, E_ifun, E_valC, E_valA, E_valB, E_srcA, E_srcB, E_dstE, E_dstM, output, widths matching REQ-005..009, registered copies.
REQ-011 SHALL have port E_valid, output, 1, high when E holds a real (non-bubble) instruction.
REQ-012 SHALL have port bubble_cnt, output, 32, count of bubbles inserted since reset.

Function
REQ-013 SHALL evaluate, per rising edge, priority rst > E_bubble > E_stall > load.
REQ-014 SHALL on load copy every d_* input into its E_* register and set E_valid=1, latency one cycle.
REQ-015 SHALL on bubble set E_icode=INOP, E_ifun=0, E_valC=E_valA=E_valB=0, E_srcA=E_srcB=E_dstE=E_dstM=RNONE, E_stat=SBUB, E_valid=0.
REQ-016 SHALL on stall (E_bubble=0) retain all E_* outputs and E_valid unchanged.
REQ-017 SHALL treat E_stall=1 with E_bubble=1 as bubble (bubble wins), no error output.
REQ-018 SHALL increment bubble_cnt by 1 on every edge where E_bubble=1 and rst=0.
REQ-019 SHALL saturate bubble_cnt at 32'hFFFF_FFFF, with no wrap.
REQ-020 SHALL leave bubble_cnt unchanged on stall or load edges.
REQ-021 SHALL drive all outputs directly from flops, with no combinational path input->output.
REQ-022 SHALL pass d_stat values through unmodified on load, including SADR/SINS, with no interpretation.

Reset
REQ-023 SHALL on rst assertion immediately, without waiting for clk, force bubble state per REQ-015 and bubble_cnt=0.
REQ-024 SHALL hold reset state while rst=1 regardless of E_stall/E_bubble.
REQ-025 SHALL perform a normal load on the first edge after rst deasserts, provided E_stall=E_bubble=0.
REQ-026 SHALL on rst asserted mid-stall discard held instruction, and SHALL NOT restore it after reset.

Structure
REQ-027 SHALL take RNONE, INOP, SAOK, SBUB, SADR, SINS from shared constants file def.v, with no local literals.
REQ-028 SHALL keep stage-field widths (ICODE, FUN, REG, STAT) as def.v constants shared with fwdA/fwdB and F/D/M/W registers.
REQ-029 SHALL instantiate one sub-module, sat_cnt32 (saturating 32-bit counter, inc/clear), for bubble_cnt.
REQ-030 SHALL contain no other sub-modules; field registers are one always block.

Verification
REQ-031 SHALL cover: rst pulse mid-cycle with d_* nonzero -> outputs to bubble state before next edge, bubble_cnt=0, E_valid=0.
REQ-032 SHALL cover: load d_valA=32'h1234_5678, d_dstE=5'd8, d_icode=6'h00, d_ifun=6'h20 -> same values on E_* one edge later, E_valid=1.
REQ-033 SHALL cover: after load, E_stall=1 for 3 edges while d_* changes -> E_* frozen at loaded values, bubble_cnt unchanged.
REQ-034 SHALL cover: E_stall=1 and E_bubble=1 same edge -> bubble state, E_stat=SBUB, bubble_cnt +1.
REQ-035 SHALL cover: force sat_cnt32 to 32'hFFFF_FFFE, two bubble edges -> 32'hFFFF_FFFF then stays 32'hFFFF_FFFF.
REQ-036 SHALL cover: d_stat=SADR loaded -> E_stat=SADR, E_valid=1, all other fields passed unchanged.
